// File: rtl/sid_pkg.sv
// sid: shared types and constants for the muladd datapath
package sid;
    typedef logic signed [31:0] s32_t;
    typedef logic signed [15:0] s16_t;
    localparam int MULADD_LATENCY = 2;
    localparam int RSP_ID_W = 2;
    typedef struct packed {
        s32_t c;
        logic s;
        s16_t a;
        s16_t b;
    } muladd_req_t;
    typedef struct packed {
        logic valid;
        logic [RSP_ID_W-1:0] id;
        s32_t o;
    } muladd_rsp_t;
    function automatic int id_width(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/muladd.sv
// muladd: combinational signed o = c +/- a*b, wrapping modulo 2^32
module muladd
    import sid::*;
(
    input  s32_t c,
    input  logic s,
    input  s16_t a,
    input  s16_t b,
    output s32_t o
);
    s32_t p;
    always_comb begin
        p = a * b;
        o = s ? c - p : c + p;
    end
endmodule

// File: rtl/sid_muladd_arb.sv
// sid_muladd_arb: arbitrates N_REQ requesters onto one pipelined muladd, 2-cycle tagged results
module sid_muladd_arb
    import sid::*;
#(
    parameter int N_REQ = 4,
    parameter bit FIXED_PRI0 = 1'b1,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*32-1:0] req_c,
    input  logic [N_REQ-1:0]   req_s,
    input  logic [N_REQ*16-1:0] req_a,
    input  logic [N_REQ*16-1:0] req_b,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_o
);
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, gnt_id, id1_q, id1_d, rsp_id_q, rsp_id_d;
    logic gnt, pri0, v1_q, v1_d, rsp_valid_q, rsp_valid_d;
    logic [ID_W:0] rr;
    logic [N_REQ-1:0] rr_mask;
    muladd_req_t op_q, op_d;
    s32_t mul_o, rsp_o_q, rsp_o_d;

    // returns {found, index} of the first set bit of v scanning upward from ptr, wrapping
    function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] v, input logic [ID_W-1:0] ptr);
        logic [ID_W:0] r;
        int k;
        r = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N_REQ;
            if (v[k]) r = {1'b1, ID_W'(k)};
        end
        return r;
    endfunction

    always_comb begin
        pri0 = FIXED_PRI0 && req_valid[0];
        rr_mask = FIXED_PRI0 ? req_valid & ~N_REQ'(1) : req_valid;
        rr = rr_pick(rr_mask, rr_ptr_q);
        gnt = pri0 || rr[ID_W];
        gnt_id = pri0 ? '0 : rr[ID_W-1:0];
        rr_ptr_d = rr_ptr_q;
        if (!pri0 && rr[ID_W]) rr_ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
        req_ready = gnt ? N_REQ'(1) << gnt_id : '0;
        op_d = op_q;
        id1_d = id1_q;
        if (gnt) begin
            op_d.c = req_c[int'(gnt_id)*32 +: 32];
            op_d.s = req_s[gnt_id];
            op_d.a = req_a[int'(gnt_id)*16 +: 16];
            op_d.b = req_b[int'(gnt_id)*16 +: 16];
            id1_d = gnt_id;
        end
        v1_d = gnt;
        rsp_valid_d = v1_q;
        rsp_id_d = id1_q;
        rsp_o_d = mul_o;
    end

    muladd u_muladd (.c(op_q.c), .s(op_q.s), .a(op_q.a), .b(op_q.b), .o(mul_o));

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            op_q <= '0;
            id1_q <= '0;
            v1_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_o_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            op_q <= op_d;
            id1_q <= id1_d;
            v1_q <= v1_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_o_q <= rsp_o_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_o = rsp_o_q;
endmodule

// File: tb/tb_sid_muladd_arb.sv
// tb_sid_muladd_arb: checks round-robin and fixed-priority instances against a queue-free behavioural model
module tb_sid_muladd_arb;
    localparam int N = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_s = '0;
    logic [N*32-1:0] req_c = '0;
    logic [N*16-1:0] req_a = '0;
    logic [N*16-1:0] req_b = '0;
    logic [N-1:0] rdy[2];
    logic rv[2];
    logic [1:0] rid[2];
    logic [31:0] ro[2];
    int checks = 0;
    int passes = 0;

    typedef struct {
        bit v;
        int id;
        logic [31:0] o;
    } rsp_m_t;
    rsp_m_t s1[2];
    rsp_m_t s2[2];
    int last[2] = '{N - 1, N - 1};

    always #5 clk = ~clk;

    sid_muladd_arb #(.N_REQ(N), .FIXED_PRI0(1'b0)) dut0 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[0]),
        .req_c(req_c), .req_s(req_s), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rv[0]), .rsp_id(rid[0]), .rsp_o(ro[0])
    );
    sid_muladd_arb #(.N_REQ(N), .FIXED_PRI0(1'b1)) dut1 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy[1]),
        .req_c(req_c), .req_s(req_s), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rv[1]), .rsp_id(rid[1]), .rsp_o(ro[1])
    );

    // next winner is the first valid requester after the last round-robin winner
    function automatic int pick(input logic [N-1:0] v, input bit fixed, input int lst);
        int k;
        if (fixed && v[0]) return 0;
        for (int d = 1; d <= N; d++) begin
            k = (lst + d) % N;
            if (v[k] && !(fixed && k == 0)) return k;
        end
        return -1;
    endfunction

    function automatic logic [31:0] ref_o(input int k);
        longint c, p, r;
        c = longint'($signed(req_c[k*32 +: 32]));
        p = longint'($signed(req_a[k*16 +: 16])) * longint'($signed(req_b[k*16 +: 16]));
        r = req_s[k] ? c - p : c + p;
        return r[31:0];
    endfunction

    function automatic logic [N-1:0] exp_rdy(input int m);
        int g;
        g = pick(req_valid, m == 1, last[m]);
        return g < 0 ? '0 : N'(1) << g;
    endfunction

    always @(posedge clk) begin : model
        for (int m = 0; m < 2; m++) begin
            int g;
            g = pick(req_valid, m == 1, last[m]);
            if (rst) begin
                last[m] <= N - 1;
                s1[m] <= '{1'b0, 0, 32'd0};
                s2[m] <= '{1'b0, 0, 32'd0};
            end else begin
                if (g >= 0 && !(m == 1 && g == 0)) last[m] <= g;
                s2[m] <= s1[m];
                if (g >= 0) s1[m] <= '{1'b1, g, ref_o(g)};
                else s1[m] <= '{1'b0, s1[m].id, s1[m].o};
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_req(input int k, input logic [31:0] c, input logic s, input logic [15:0] a, input logic [15:0] b);
        req_c[k*32 +: 32] = c;
        req_s[k] = s;
        req_a[k*16 +: 16] = a;
        req_b[k*16 +: 16] = b;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) set_req(k, $urandom, 1'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        tick();
        tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== 1'b0) $display("FAIL reset_valid dut%0d: got %b want 0", m, rv[m]); else passes++;
            checks++; if (rid[m] !== 2'd0) $display("FAIL reset_id dut%0d: got %0d want 0", m, rid[m]); else passes++;
            checks++; if (ro[m] !== 32'd0) $display("FAIL reset_o dut%0d: got %h want 0", m, ro[m]); else passes++;
            checks++; if (rdy[m] !== 4'b0001) $display("FAIL reset_ready_all dut%0d: got %b want 0001", m, rdy[m]); else passes++;
        end
        req_valid = 4'b0110;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rdy[m] !== 4'b0010) $display("FAIL reset_ready_0110 dut%0d: got %b want 0010", m, rdy[m]); else passes++;
        end
        req_valid = '0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rdy[m] !== 4'b0000) $display("FAIL reset_ready_none dut%0d: got %b want 0000", m, rdy[m]); else passes++;
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_op(input int k, input logic [31:0] c, input logic s, input logic [15:0] a,
                                  input logic [15:0] b, input logic [31:0] exp_o, input string nm);
        set_req(k, c, s, a, b);
        req_valid = N'(1) << k;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rdy[m] !== N'(1) << k) $display("FAIL %s_ready dut%0d: got %b want %b", nm, m, rdy[m], N'(1) << k); else passes++;
        end
        tick();
        req_valid = '0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== 1'b0) $display("FAIL %s_early dut%0d: got %b want 0", nm, m, rv[m]); else passes++;
        end
        tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== 1'b1) $display("FAIL %s_valid dut%0d: got %b want 1", nm, m, rv[m]); else passes++;
            checks++; if (rid[m] !== 2'(k)) $display("FAIL %s_id dut%0d: got %0d want %0d", nm, m, rid[m], k); else passes++;
            checks++; if (ro[m] !== exp_o) $display("FAIL %s_o dut%0d: got %h want %h", nm, m, ro[m], exp_o); else passes++;
        end
        tick();
    endtask

    task automatic test_rr_all();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_valid = i < 8 ? '1 : '0;
            rand_ops();
            #1;
            if (i < 8) begin
                checks++; if (rdy[0] !== N'(1) << (i % N)) $display("FAIL rr_grant cyc%0d: got %b want %b", i, rdy[0], N'(1) << (i % N)); else passes++;
                checks++; if (rdy[1] !== 4'b0001) $display("FAIL rr_pri0_grant cyc%0d: got %b want 0001", i, rdy[1]); else passes++;
            end
            if (i >= 2) begin
                checks++; if (rv[0] !== 1'b1) $display("FAIL rr_valid cyc%0d: got %b want 1", i, rv[0]); else passes++;
                checks++; if (rid[0] !== 2'((i - 2) % N)) $display("FAIL rr_id cyc%0d: got %0d want %0d", i, rid[0], (i - 2) % N); else passes++;
                checks++; if (ro[0] !== s2[0].o) $display("FAIL rr_o cyc%0d: got %h want %h", i, ro[0], s2[0].o); else passes++;
            end
            tick();
        end
    endtask

    task automatic test_alt_pri();
        int wt[N];
        int maxw;
        logic [N-1:0] e1;
        maxw = 0;
        for (int k = 0; k < N; k++) wt[k] = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            req_valid = {3'b111, 1'(i % 2 == 0)};
            rand_ops();
            #1;
            e1 = (i % 2 == 0) ? 4'b0001 : 4'b0001 << (1 + ((i - 1) / 2) % 3);
            checks++; if (rdy[1] !== e1) $display("FAIL alt_pri_grant cyc%0d: got %b want %b", i, rdy[1], e1); else passes++;
            for (int m = 0; m < 2; m++) begin
                checks++; if (rv[m] !== s2[m].v) $display("FAIL alt_valid dut%0d cyc%0d: got %b want %b", m, i, rv[m], s2[m].v); else passes++;
                if (s2[m].v) begin
                    checks++; if (rid[m] !== 2'(s2[m].id) || ro[m] !== s2[m].o) $display("FAIL alt_rsp dut%0d cyc%0d: got %0d/%h want %0d/%h", m, i, rid[m], ro[m], s2[m].id, s2[m].o); else passes++;
                end
            end
            checks++; if (rdy[0] !== exp_rdy(0)) $display("FAIL alt_rr_grant cyc%0d: got %b want %b", i, rdy[0], exp_rdy(0)); else passes++;
            for (int k = 0; k < N; k++) begin
                wt[k] = (req_valid[k] && !rdy[1][k]) ? wt[k] + 1 : 0;
                if (wt[k] > maxw) maxw = wt[k];
            end
            tick();
        end
        checks++; if (maxw > 2 * N) $display("FAIL alt_starvation: got wait %0d want <= %0d", maxw, 2 * N); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(3, 32'd5, 1'b0, 16'd2, 16'd2);
        req_valid = 4'b1000;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rdy[m] !== 4'b1000) $display("FAIL mid_grant dut%0d: got %b want 1000", m, rdy[m]); else passes++;
        end
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_valid = 4'b1110;
        set_req(1, 32'd10, 1'b1, 16'd3, 16'd4);
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== 1'b0 || ro[m] !== 32'd0) $display("FAIL mid_discard dut%0d: got %b/%h want 0/0", m, rv[m], ro[m]); else passes++;
            checks++; if (rdy[m] !== 4'b0010) $display("FAIL mid_first_grant dut%0d: got %b want 0010", m, rdy[m]); else passes++;
        end
        tick();
        req_valid = '0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== 1'b0 || ro[m] !== 32'd0) $display("FAIL mid_discard2 dut%0d: got %b/%h want 0/0", m, rv[m], ro[m]); else passes++;
        end
        tick();
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++; if (rv[m] !== 1'b1 || rid[m] !== 2'd1 || ro[m] !== 32'hFFFF_FFFE) $display("FAIL mid_after dut%0d: got %b/%0d/%h want 1/1/fffffffe", m, rv[m], rid[m], ro[m]); else passes++;
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            req_valid = N'($urandom);
            rand_ops();
            #1;
            for (int m = 0; m < 2; m++) begin
                checks++; if (rdy[m] !== exp_rdy(m)) $display("FAIL rnd_grant dut%0d cyc%0d: got %b want %b", m, i, rdy[m], exp_rdy(m)); else passes++;
                checks++; if (rv[m] !== s2[m].v) $display("FAIL rnd_valid dut%0d cyc%0d: got %b want %b", m, i, rv[m], s2[m].v); else passes++;
                if (s2[m].v) begin
                    checks++; if (rid[m] !== 2'(s2[m].id) || ro[m] !== s2[m].o) $display("FAIL rnd_rsp dut%0d cyc%0d: got %0d/%h want %0d/%h", m, i, rid[m], ro[m], s2[m].id, s2[m].o); else passes++;
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_op(0, 32'd100, 1'b0, 16'd3, -16'sd7, 32'd79, "single");
        test_single_op(2, 32'd0, 1'b1, 16'h8000, 16'h8000, 32'hC000_0000, "subtract");
        test_single_op(1, 32'h7FFF_FFFF, 1'b0, 16'd1, 16'd1, 32'h8000_0000, "wrap");
        test_rr_all();
        test_alt_pri();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
